// File: rtl/dmtd_pkg.sv
// Shared types and constants for the DMTD phase meter.
//   dg_state_t       : deglitch state of one sampled channel (LOW/HIGH)
//   SYNC_STAGES_SIM  : synchronizer depth used in simulation builds
//   SYNC_STAGES_HW   : synchronizer depth used in hardware builds
package dmtd_pkg;

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } dg_state_t;

    localparam int unsigned SYNC_STAGES_SIM = 2;
    localparam int unsigned SYNC_STAGES_HW  = 3;

endpackage

// File: rtl/dmtd_deglitch.sv
// One DMTD channel: synchronizes an asynchronous clock input into the helper
// domain, deglitches the resulting beat waveform and reports accepted rising
// edges together with the timestamp of the first 1 of the accepted run.
// Ports:
//   clkdmtd   in   helper clock
//   rstn      in   synchronous active-low reset
//   din       in   asynchronous input (clka or clkb)
//   stableval in   required run length; 0 behaves as 1
//   ts        in   free-running timestamp from the top level
//   rise      out  one-cycle pulse per accepted rising edge
//   rise_ts   out  timestamp of the accepted edge (valid with rise)
module dmtd_deglitch
    import dmtd_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_HW,
    parameter int unsigned TSW    = 14
) (
    input  logic            clkdmtd,
    input  logic            rstn,
    input  logic            din,
    input  logic [31:0]     stableval,
    input  logic [TSW-1:0]  ts,
    output logic            rise,
    output logic [TSW-1:0]  rise_ts
);

    logic [STAGES-1:0] sync;
    logic              samp;
    logic              samp_prev;
    logic [31:0]       run_cnt;
    logic [TSW-1:0]    run_start;
    dg_state_t         state;

    logic              changed;
    logic [31:0]       run_len;
    logic [31:0]       thresh;
    logic              stable;
    logic [TSW-1:0]    start_now;

    assign samp = sync[STAGES-1];

    // run_len counts the current cycle, so a fresh run is length 1 on the
    // very cycle its first sample appears; the counter saturates.
    always_comb begin
        changed   = (samp != samp_prev);
        run_len   = changed ? 32'd1 :
                    ((run_cnt == '1) ? run_cnt : run_cnt + 32'd1);
        thresh    = (stableval == '0) ? 32'd1 : stableval;
        stable    = (run_len >= thresh);
        start_now = changed ? ts : run_start;
    end

    always_ff @(posedge clkdmtd) begin
        if (!rstn) begin
            sync      <= '0;
            samp_prev <= 1'b0;
            run_cnt   <= '0;
            run_start <= '0;
            state     <= LOW;
            rise      <= 1'b0;
            rise_ts   <= '0;
        end else begin
            sync      <= {sync[STAGES-2:0], din};
            samp_prev <= samp;
            run_cnt   <= run_len;
            run_start <= start_now;
            rise      <= 1'b0;
            case (state)
                LOW: begin
                    if (samp && stable) begin
                        state   <= HIGH;
                        rise    <= 1'b1;
                        rise_ts <= start_now;
                    end
                end
                HIGH: begin
                    if (!samp && stable) begin
                        state <= LOW;
                    end
                end
                default: state <= LOW;
            endcase
        end
    end

endmodule

// File: rtl/dmtd_phase_meter.sv
// DMTD phase meter: measures, in helper-clock cycles, the delay from the
// deglitched a-beat rising edge to the following b-beat rising edge.
// Optional feature macro: DMTD_PERIOD_EN (adds a-beat period measurement).
// Ports:
//   clkdmtd     in   helper sampling clock (only clock)
//   rstn        in   synchronous active-low reset
//   clka, clkb  in   reference / measured clocks, sampled as data
//   stableval   in   deglitch run length in helper cycles (0 behaves as 1)
//   phaseab     out  last a-to-b delay, zero-extended from FOFFSETWIDTH
//   stb_phaseab out  one-cycle strobe when phaseab updates
//   period      out  (DMTD_PERIOD_EN) last a-to-a interval, zero-extended
//   stb_period  out  (DMTD_PERIOD_EN) one-cycle strobe when period updates
module dmtd_phase_meter
    import dmtd_pkg::*;
#(
    parameter int          SIM          = 0,
    parameter int unsigned FOFFSETWIDTH = 14
) (
    input  logic        clkdmtd,
    input  logic        rstn,
    input  logic        clka,
    input  logic        clkb,
    input  logic [31:0] stableval,
    output logic [31:0] phaseab,
    output logic        stb_phaseab
`ifdef DMTD_PERIOD_EN
    ,
    output logic [31:0] period,
    output logic        stb_period
`endif
);

    localparam int unsigned STAGES = (SIM != 0) ? SYNC_STAGES_SIM : SYNC_STAGES_HW;

    logic [FOFFSETWIDTH-1:0] ts;
    logic [FOFFSETWIDTH-1:0] ta;
    logic                    armed;
    logic                    rise_a, rise_b;
    logic [FOFFSETWIDTH-1:0] ts_a, ts_b;
    logic [FOFFSETWIDTH-1:0] ta_eff;
    logic [FOFFSETWIDTH-1:0] phase_diff;

    dmtd_deglitch #(.STAGES(STAGES), .TSW(FOFFSETWIDTH)) u_dg_a (
        .clkdmtd   (clkdmtd),
        .rstn      (rstn),
        .din       (clka),
        .stableval (stableval),
        .ts        (ts),
        .rise      (rise_a),
        .rise_ts   (ts_a)
    );

    dmtd_deglitch #(.STAGES(STAGES), .TSW(FOFFSETWIDTH)) u_dg_b (
        .clkdmtd   (clkdmtd),
        .rstn      (rstn),
        .din       (clkb),
        .stableval (stableval),
        .ts        (ts),
        .rise      (rise_b),
        .rise_ts   (ts_b)
    );

    // Same-cycle a and b edges: the new a timestamp is used directly.
    always_comb begin
        ta_eff     = rise_a ? ts_a : ta;
        phase_diff = ts_b - ta_eff;
    end

    always_ff @(posedge clkdmtd) begin
        if (!rstn) begin
            ts          <= '0;
            ta          <= '0;
            armed       <= 1'b0;
            phaseab     <= '0;
            stb_phaseab <= 1'b0;
        end else begin
            ts          <= ts + FOFFSETWIDTH'(1);
            stb_phaseab <= 1'b0;
            if (rise_a) begin
                ta    <= ts_a;
                armed <= 1'b1;
            end
            // Placed after the a-edge update so disarming wins on a tie.
            if (rise_b && (armed || rise_a)) begin
                phaseab     <= 32'(phase_diff);
                stb_phaseab <= 1'b1;
                armed       <= 1'b0;
            end
        end
    end

`ifdef DMTD_PERIOD_EN
    logic have_a;

    always_ff @(posedge clkdmtd) begin
        if (!rstn) begin
            have_a     <= 1'b0;
            period     <= '0;
            stb_period <= 1'b0;
        end else begin
            stb_period <= 1'b0;
            if (rise_a) begin
                have_a <= 1'b1;
                if (have_a) begin
                    period     <= 32'(ts_a - ta);
                    stb_period <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmtd_phase_meter.sv
// Bench for dmtd_phase_meter (SIM=1, FOFFSETWIDTH=9). Expected phases are
// derived from the timestamps at which the bench drives the input edges:
// both channels share the same pipeline, so phase = (tb_drive - ta_drive)
// mod 512. A per-cycle compare process checks phaseab against the held
// expectation and consumes one queued expectation per strobe.
module tb_dmtd_phase_meter;

    localparam int unsigned W   = 9;
    localparam int          MOD = 512;

    logic        clk;
    logic        rstn;
    logic        clka, clkb;
    logic [31:0] stableval;
    logic [31:0] phaseab;
    logic        stb_phaseab;
`ifdef DMTD_PERIOD_EN
    logic [31:0] period;
    logic        stb_period;
`endif

    dmtd_phase_meter #(.SIM(1), .FOFFSETWIDTH(W)) dut (
        .clkdmtd     (clk),
        .rstn        (rstn),
        .clka        (clka),
        .clkb        (clkb),
        .stableval   (stableval),
        .phaseab     (phaseab),
        .stb_phaseab (stb_phaseab)
`ifdef DMTD_PERIOD_EN
        ,
        .period      (period),
        .stb_period  (stb_period)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int nstb  = 0;
    int ts_m  = 0;
    logic rst_q = 1'b0;
    logic prev_stb = 1'b0;
    logic [31:0] model_phase = '0;
    int exp_q[$];
`ifdef DMTD_PERIOD_EN
    int nper = 0;
    logic [31:0] last_period = '0;
`endif

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Timestamp as seen by the design: held at 0 in reset, +1 per cycle.
    always @(posedge clk) begin
        rst_q <= !rstn;
        if (!rstn) ts_m <= 0;
        else       ts_m <= (ts_m + 1) % MOD;
    end

    always @(negedge clk) begin
        if (rst_q) begin
            model_phase = '0;
            exp_q.delete();
            check("reset_phaseab", phaseab, 32'd0);
            check("reset_stb", {31'd0, stb_phaseab}, 32'd0);
        end else begin
            if (stb_phaseab) begin
                nstb++;
                check("stb_single_cycle", {31'd0, prev_stb}, 32'd0);
                check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) model_phase = 32'(exp_q.pop_front());
            end
            check("phaseab", phaseab, model_phase);
        end
        prev_stb = stb_phaseab;
`ifdef DMTD_PERIOD_EN
        if (!rst_q && stb_period) begin
            nper++;
            last_period = period;
        end
`endif
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_ts(input int v);
        int k;
        k = 0;
        while (ts_m != v && k < 1100) begin
            cyc(1);
            k++;
        end
        if (ts_m != v) check("wait_ts_timeout", 32'(ts_m), 32'(v));
    endtask

    task automatic wait_strobe();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            cyc(1);
            k++;
        end
        check("strobe_arrived", 32'(exp_q.size()), 32'd0);
        cyc(2);
    endtask

    function automatic int mdiff(input int tb, input int ta);
        return (tb - ta + MOD) % MOD;
    endfunction

    int ta_d, tb_d, s0;

    initial begin
        rstn = 1'b0; clka = 1'b0; clkb = 1'b0; stableval = 32'd4;
        cyc(10);
        rstn = 1'b1;
        cyc(20);
        check("no_strobe_after_release", 32'(nstb), 32'd0);

        // Basic phase: a at ts=100, b at ts=137.
        s0 = nstb;
        wait_ts(100); clka = 1'b1; ta_d = ts_m;
        wait_ts(137); clkb = 1'b1; tb_d = ts_m;
        exp_q.push_back(mdiff(tb_d, ta_d));
        wait_strobe();
        check("basic_phase_literal", phaseab, 32'd37);
        check("basic_strobe_count", 32'(nstb - s0), 32'd1);
        clka = 1'b0; clkb = 1'b0;
        cyc(10);

        // Glitch: 1,0,1,0 single-cycle pulses, then a held from ts=200.
        s0 = nstb;
        wait_ts(192);
        clka = 1'b1; cyc(1); clka = 1'b0; cyc(1);
        clka = 1'b1; cyc(1); clka = 1'b0;
        wait_ts(200); clka = 1'b1; ta_d = ts_m;
        wait_ts(250); clkb = 1'b1; tb_d = ts_m;
        exp_q.push_back(mdiff(tb_d, ta_d));
        wait_strobe();
        check("glitch_phase_literal", phaseab, 32'd50);
        check("glitch_strobe_count", 32'(nstb - s0), 32'd1);
        clka = 1'b0; clkb = 1'b0;
        cyc(10);

        // Wrap-around: a at ts=500, b at ts=20 after the wrap.
        wait_ts(500); clka = 1'b1; ta_d = ts_m;
        wait_ts(20);  clkb = 1'b1; tb_d = ts_m;
        exp_q.push_back(mdiff(tb_d, ta_d));
        wait_strobe();
        check("wrap_phase_literal", phaseab, 32'd32);
        clka = 1'b0; clkb = 1'b0;
        cyc(10);

        // Two b-edges with nothing armed: no strobe, phaseab held.
        s0 = nstb;
        clkb = 1'b1; cyc(10); clkb = 1'b0; cyc(10);
        clkb = 1'b1; cyc(10); clkb = 1'b0; cyc(10);
        check("b_only_no_strobe", 32'(nstb - s0), 32'd0);
        check("b_only_phase_held", phaseab, 32'd32);

        // a and b accepted in the same cycle.
        s0 = nstb;
        clka = 1'b1; clkb = 1'b1;
        exp_q.push_back(0);
        wait_strobe();
        check("same_cycle_phase", phaseab, 32'd0);
        check("same_cycle_count", 32'(nstb - s0), 32'd1);
        clka = 1'b0; clkb = 1'b0;
        cyc(10);

        // stableval=0 behaves as 1.
        stableval = 32'd0;
        clka = 1'b1; ta_d = ts_m;
        cyc(5);
        clkb = 1'b1; tb_d = ts_m;
        exp_q.push_back(mdiff(tb_d, ta_d));
        wait_strobe();
        check("stableval0_phase", phaseab, 32'd5);
        clka = 1'b0; clkb = 1'b0;
        stableval = 32'd4;
        cyc(10);

        // Reset while armed: the stale a-edge must not pair with a later b.
        s0 = nstb;
        clka = 1'b1; cyc(12);
        rstn = 1'b0; clka = 1'b0;
        cyc(3);
        rstn = 1'b1;
        cyc(10);
        clkb = 1'b1; cyc(30);
        check("reset_disarms", 32'(nstb - s0), 32'd0);
        clkb = 1'b0; cyc(10);
        clka = 1'b1; ta_d = ts_m;
        cyc(7);
        clkb = 1'b1; tb_d = ts_m;
        exp_q.push_back(mdiff(tb_d, ta_d));
        wait_strobe();
        check("post_reset_phase", phaseab, 32'd7);
        clka = 1'b0; clkb = 1'b0;
        cyc(10);

`ifdef DMTD_PERIOD_EN
        rstn = 1'b0; cyc(3); rstn = 1'b1;
        nper = 0;
        wait_ts(10);  clka = 1'b1;
        cyc(20); clka = 1'b0; cyc(20);
        wait_ts(310); clka = 1'b1;
        cyc(20);
        check("period_strobe_count", 32'(nper), 32'd1);
        check("period_value", last_period, 32'd300);
        clka = 1'b0;
        cyc(10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
